csel_wide_add_seq: RTL and testbench

//  Multi-cycle sequencer that adds two WORDS*width-bit operands using one shared width-bit

---
 rtl/csel_pkg.sv | 15 +
 rtl/C_Sel_A_19bit.sv | 37 +++
 rtl/csel_wide_add_seq.sv | 131 +++++++++++++
 tb/tb_csel_wide_add_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared definitions for the wide carry-select add sequencer: FSM states and default geometry.
package csel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CSEL_W     = 19;
  localparam int CSEL_WORDS = 4;
  // Bits per carry-select block inside the slice adder.
  localparam int CSEL_BLK   = 5;

endpackage

// File: rtl/C_Sel_A_19bit.sv
// Combinational carry-select adder slice: each block precomputes sums for carry-in 0 and 1.
module C_Sel_A_19bit
  import csel_pkg::*;
#(
  parameter int width = CSEL_W
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] s,
  output logic             cout
);

  localparam int NBLK = (width + CSEL_BLK - 1) / CSEL_BLK;

  logic [NBLK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int LO = i * CSEL_BLK;
    localparam int BW = ((width - LO) < CSEL_BLK) ? (width - LO) : CSEL_BLK;

    logic [BW:0] s0;
    logic [BW:0] s1;

    assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
    assign s1 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]} + (BW + 1)'(1);

    // Incoming block carry only steers the mux; it never enters this block's adders.
    assign s[LO +: BW] = c[i] ? s1[BW-1:0] : s0[BW-1:0];
    assign c[i+1]      = c[i] ? s1[BW]     : s0[BW];
  end

  assign cout = c[NBLK];

endmodule

// File: rtl/csel_wide_add_seq.sv
// Adds two WORDS*width operands one word per cycle through a single shared carry-select slice.
// Optional subtract mode is enabled by defining CSEL_SUB_EN.
module csel_wide_add_seq
  import csel_pkg::*;
#(
  parameter int width = CSEL_W,
  parameter int WORDS = CSEL_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*width-1:0] in_a,
  input  logic [WORDS*width-1:0] in_b,
  input  logic                   in_cin,
`ifdef CSEL_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*width-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int TOT   = WORDS * width;
  localparam int IDX_W = $clog2(WORDS);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [TOT-1:0]     a_reg;
  logic [TOT-1:0]     b_reg;
  logic               accept;
  logic               last_word;
  logic [width-1:0]   a_word;
  logic [width-1:0]   b_word;
  logic [width-1:0]   s_word;
  logic               c_word;
`ifdef CSEL_SUB_EN
  logic               sub_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign last_word = (idx == IDX_W'(WORDS - 1));

  // Word mux: select the current slice of each latched operand.
  assign a_word = a_reg[idx*width +: width];
`ifdef CSEL_SUB_EN
  assign b_word = sub_reg ? ~b_reg[idx*width +: width] : b_reg[idx*width +: width];
`else
  assign b_word = b_reg[idx*width +: width];
`endif

  C_Sel_A_19bit #(
    .width (width)
  ) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .s    (s_word),
    .cout (c_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            idx   <= '0;
`ifdef CSEL_SUB_EN
            sub_reg <= in_sub;
            carry   <= in_sub ? 1'b1 : in_cin;
`else
            carry   <= in_cin;
`endif
          end
        end
        RUN: begin
          out_sum[idx*width +: width] <= s_word;
          carry                       <= c_word;
          // Top-word carry goes only to out_cout; idx parks at 0 for the next op.
          if (last_word) begin
            out_cout <= c_word;
            idx      <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csel_wide_add_seq.sv
// Self-checking bench for csel_wide_add_seq (76-bit operands, 4 words of 19 bits).
module tb_csel_wide_add_seq;

  localparam int W     = 19;
  localparam int WORDS = 4;
  localparam int TOT   = W * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [TOT-1:0] in_a;
  logic [TOT-1:0] in_b;
  logic           in_cin;
`ifdef CSEL_SUB_EN
  logic           in_sub;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [TOT-1:0] out_sum;
  logic           out_cout;
  logic           busy;

  int  checks = 0;
  int  errors = 0;
  bit  cur_sub = 1'b0;

  csel_wide_add_seq #(.width(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CSEL_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {cout,sum} = a+b+cin, or for subtract sum = a-b mod 2^TOT, cout = no borrow.
  function automatic logic [TOT:0] model(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                                         input logic cin, input bit sub);
    logic [TOT:0] r;
    if (sub) begin
      r[TOT-1:0] = a - b;
      r[TOT]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, cin};
    end
    return r;
  endfunction

  function automatic logic [TOT-1:0] rand_op();
    logic [95:0] r;
    int unsigned k;
    r = {$urandom(), $urandom(), $urandom()};
    k = $urandom_range(0, 7);
    if (k == 0) r = '1;
    else if (k == 1) r = '0;
    return r[TOT-1:0];
  endfunction

  // Presents one operand set and waits for out_valid; completes the handshake if out_ready.
  task automatic run_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic cin,
                        output logic [TOT-1:0] s, output logic co, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    lat = 0;
    s = '0;
    co = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef CSEL_SUB_EN
    in_sub = cur_sub;
`endif
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    s = out_sum;
    co = out_cout;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
`ifdef CSEL_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_sum !== '0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: out_sum=%h out_cout=%b, required 0 0", out_sum, out_cout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [TOT-1:0] s;
    logic co;
    int lat;
    bit ok;
    logic [TOT-1:0] ones;
    ones = '1;
    out_ready = 1'b1;
    run_op(ones, '0, 1'b1, s, co, lat, ok);
    checks++;
    if (!ok || s !== '0 || co !== 1'b1) begin
      errors++;
      $display("FAIL ripple_all: ok=%b sum=%h cout=%b, required sum=0 cout=1", ok, s, co);
    end
    checks++;
    if (lat !== WORDS) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, WORDS);
    end
    run_op(TOT'(20'h7FFFF), TOT'(1), 1'b0, s, co, lat, ok);
    checks++;
    if (!ok || s !== TOT'(20'h80000) || co !== 1'b0) begin
      errors++;
      $display("FAIL word0_carry: ok=%b sum=%h cout=%b, required sum=80000 cout=0", ok, s, co);
    end
  endtask

  task automatic test_hold();
    logic [TOT-1:0] s;
    logic [TOT-1:0] a;
    logic [TOT-1:0] b;
    logic [TOT:0] exp_v;
    logic co;
    int lat;
    bit ok;
    a = rand_op();
    b = rand_op();
    exp_v = model(a, b, 1'b1, 1'b0);
    out_ready = 1'b0;
    run_op(a, b, 1'b1, s, co, lat, ok);
    checks++;
    if (!ok || lat !== WORDS || {co, s} !== exp_v) begin
      errors++;
      $display("FAIL hold_result: ok=%b lat=%0d got %h, required lat %0d value %h",
               ok, lat, {co, s}, WORDS, exp_v);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp_v) begin
        errors++;
        $display("FAIL hold_stall: cycle %0d out_valid=%b in_ready=%b value=%h, required 1 0 %h",
                 i, out_valid, in_ready, {out_cout, out_sum}, exp_v);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_return: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    logic [TOT-1:0] s;
    logic [TOT-1:0] a;
    logic [TOT-1:0] b;
    logic [TOT:0] exp_v;
    logic co;
    int lat;
    bit ok;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = '1;
    in_b = '1;
    in_cin = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_sum === '0) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b out_sum=%h, required busy=1 with partial sum", busy, out_sum);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 1 0 0 0 0",
               in_ready, out_valid, busy, out_sum, out_cout);
    end
    @(posedge clk);
    #1;
    a = rand_op();
    b = rand_op();
    exp_v = model(a, b, 1'b0, 1'b0);
    run_op(a, b, 1'b0, s, co, lat, ok);
    checks++;
    if (!ok || {co, s} !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_after: ok=%b got %h, required %h", ok, {co, s}, exp_v);
    end
  endtask

`ifdef CSEL_SUB_EN
  task automatic test_sub();
    logic [TOT-1:0] s;
    logic [TOT-1:0] m2;
    logic co;
    int lat;
    bit ok;
    m2 = '1;
    m2[0] = 1'b0;
    out_ready = 1'b1;
    cur_sub = 1'b1;
    run_op(TOT'(5), TOT'(7), 1'b0, s, co, lat, ok);
    checks++;
    if (!ok || s !== m2 || co !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: ok=%b sum=%h cout=%b, required %h 0", ok, s, co, m2);
    end
    run_op(TOT'(7), TOT'(5), 1'b1, s, co, lat, ok);
    checks++;
    if (!ok || s !== TOT'(2) || co !== 1'b1) begin
      errors++;
      $display("FAIL sub_plain: ok=%b sum=%h cout=%b, required 2 1", ok, s, co);
    end
    cur_sub = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [TOT:0] q[$];
    logic [TOT:0] exp_v;
    logic [TOT-1:0] ra;
    logic [TOT-1:0] rb;
    logic rc;
    bit rs;
    bit have;
    int done_ops;
    int cyc;
    have = 1'b0;
    done_ops = 0;
    cyc = 0;
    ra = '0;
    rb = '0;
    rc = 1'b0;
    rs = 1'b0;
    while (done_ops < 500 && cyc < 20000) begin
      if (!have) begin
        ra = rand_op();
        rb = rand_op();
        rc = 1'($urandom_range(0, 1));
`ifdef CSEL_SUB_EN
        rs = 1'($urandom_range(0, 1));
`endif
        have = ($urandom_range(0, 3) != 0);
      end
      in_valid = have;
      in_a = ra;
      in_b = rb;
      in_cin = rc;
`ifdef CSEL_SUB_EN
      in_sub = rs;
`endif
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (busy) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: in_ready=%b while busy, required 0", in_ready);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(ra, rb, rc, rs));
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result %h with no accepted op, required none", {out_cout, out_sum});
        end else begin
          exp_v = q.pop_front();
          if ({out_cout, out_sum} !== exp_v) begin
            errors++;
            $display("FAIL rand_sum: op %0d got %h, required %h", done_ops, {out_cout, out_sum}, exp_v);
          end
        end
        done_ops++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (done_ops < 500) begin
      errors++;
      $display("FAIL rand_timeout: completed %0d ops, required 500", done_ops);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_rst_mid();
`ifdef CSEL_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
